// File: rtl/tx_ctrl_regfile.sv
// tx_ctrl_regfile: host register bank and burst sequencer for the I2C
// transmit path. Holds SIZE/BURST, issues one tx_start per beat, counts
// tx_beat_done completions and reports BUSY/DONE/ERR.
// Optional feature macro: TXCTRL_IRQ_EN (adds irq port and CTRL.IRQ_EN).
module tx_ctrl_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_size,
  input  logic              tx_beat_done,
  output logic              tx_abort,
`ifdef TXCTRL_IRQ_EN
  output logic              irq,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] burst_q, burst_d;
  logic [DATA_W-1:0] remain_q, remain_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rvalid_q;
  logic              tx_start_q, tx_start_d;
  logic              tx_abort_q, tx_abort_d;
  logic              abort_pend_q, abort_pend_d;
`ifdef TXCTRL_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              irq_q;
`endif

  logic ctrl_wr, size_wr, burst_wr, status_wr;
  logic start_cmd, abort_cmd, busy_w, abort_now;
  logic done_set, err_set;

  // Write decode; ABORT in the same CTRL write suppresses START.
  always_comb begin
    ctrl_wr   = wr_en && (addr == ADDR_W'(0));
    size_wr   = wr_en && (addr == ADDR_W'(1));
    burst_wr  = wr_en && (addr == ADDR_W'(2));
    status_wr = wr_en && (addr == ADDR_W'(3));
    abort_cmd = ctrl_wr && wdata[1];
    start_cmd = ctrl_wr && wdata[0] && !wdata[1];
    busy_w    = (state_q != S_IDLE);
    // An abort is acted on one edge after it is written, if still busy.
    abort_now = abort_pend_q && busy_w;
  end

  // Sequencer next-state, beat counting and sticky status sets.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_cmd) begin
          if (burst_q != '0) begin
            state_d  = S_ISSUE;
            remain_d = burst_q;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_beat_done) begin
          remain_d = remain_q - DATA_W'(1);
          if (remain_q == DATA_W'(1)) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any progress made in the same cycle.
    if (abort_now) begin
      state_d  = S_IDLE;
      remain_d = remain_q;
      done_set = 1'b0;
    end
    if (busy_w && (start_cmd || size_wr || burst_wr))
      err_set = 1'b1;
    // Only latch a pending abort if the burst is not already ending.
    abort_pend_d = abort_cmd && busy_w && (state_d != S_IDLE);
    tx_start_d   = (state_q == S_ISSUE) && !abort_now;
    tx_abort_d   = abort_now;
  end

  // Register file updates and registered read mux (pre-write values).
  always_comb begin
    size_d  = (size_wr && !busy_w) ? wdata : size_q;
    burst_d = (burst_wr && !busy_w) ? wdata : burst_q;
    done_d  = done_set | (done_q & ~(status_wr & wdata[1]));
    err_d   = err_set | (err_q & ~(status_wr & wdata[2]));
`ifdef TXCTRL_IRQ_EN
    irq_en_d = ctrl_wr ? wdata[2] : irq_en_q;
`endif
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      if (addr == ADDR_W'(0)) begin
`ifdef TXCTRL_IRQ_EN
        rdata_d[2] = irq_en_q;
`endif
      end else if (addr == ADDR_W'(1)) begin
        rdata_d = size_q;
      end else if (addr == ADDR_W'(2)) begin
        rdata_d = burst_q;
      end else if (addr == ADDR_W'(3)) begin
        rdata_d[0] = busy_w;
        rdata_d[1] = done_q;
        rdata_d[2] = err_q;
      end else if (addr == ADDR_W'(4)) begin
        rdata_d = remain_q;
      end
    end
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      size_q       <= '0;
      burst_q      <= '0;
      remain_q     <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_abort_q   <= 1'b0;
      abort_pend_q <= 1'b0;
`ifdef TXCTRL_IRQ_EN
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      remain_q     <= remain_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rvalid_q     <= rd_en;
      tx_start_q   <= tx_start_d;
      tx_abort_q   <= tx_abort_d;
      abort_pend_q <= abort_pend_d;
`ifdef TXCTRL_IRQ_EN
      irq_en_q     <= irq_en_d;
      irq_q        <= done_q & irq_en_q;
`endif
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign tx_start = tx_start_q;
  assign tx_abort = tx_abort_q;
  assign tx_size  = size_q;
  assign busy     = busy_w;
`ifdef TXCTRL_IRQ_EN
  assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_tx_ctrl_regfile.sv
// Directed self-checking bench for tx_ctrl_regfile.
module tb_tx_ctrl_regfile;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid, tx_start, tx_abort, busy;
  logic [DATA_W-1:0] tx_size;
  logic              tx_beat_done;
`ifdef TXCTRL_IRQ_EN
  logic              irq;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  tx_ctrl_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .tx_start(tx_start),
    .tx_size(tx_size), .tx_beat_done(tx_beat_done), .tx_abort(tx_abort),
`ifdef TXCTRL_IRQ_EN
    .irq(irq),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    tick();
    wr_en = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk(tag, 32'(rdata), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    tx_beat_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_abort", 32'(tx_abort), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_tx_size", 32'(tx_size), 0);
`ifdef TXCTRL_IRQ_EN
    chk("rst_irq", 32'(irq), 0);
`endif
    for (int a = 0; a < 8; a++) rd(ADDR_W'(a), 8'h00, "rst_read");
    tick();
    chk("rvalid_one_cycle", 32'(rvalid), 0);

    // Normal 3-beat burst
    wr(3'd2, 8'd3);
    wr(3'd1, 8'h2A);
    chk("tx_size_2A", 32'(tx_size), 32'h2A);
    rd(3'd1, 8'h2A, "size_rb");
    rd(3'd2, 8'd3, "burst_rb");
    wr(3'd0, 8'h01);
    chk("start_busy", 32'(busy), 1);
    chk("start_no_early_pulse", 32'(tx_start), 0);
    rd(3'd4, 8'd3, "remain3");
    chk("tx_start_beat0", 32'(tx_start), 1);
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("tx_start_width", 32'(tx_start), 0);
      tick();
      tx_beat_done = 1'b1;
      tick();
      tx_beat_done = 1'b0;
      if (b < 2) begin
        chk("mid_busy", 32'(busy), 1);
        rd(3'd4, DATA_W'(2 - b), "remain_mid");
        chk("tx_start_next", 32'(tx_start), 1);
        chk("tx_size_hold", 32'(tx_size), 32'h2A);
      end else begin
        chk("end_busy", 32'(busy), 0);
        rd(3'd4, 8'd0, "remain0");
        rd(3'd3, 8'h02, "status_done");
        chk("no_extra_start", 32'(tx_start), 0);
      end
    end
    wr(3'd3, 8'h02);
    rd(3'd3, 8'h00, "done_w1c");

    // START with BURST=0
    wr(3'd2, 8'd0);
    wr(3'd0, 8'h01);
    chk("b0_busy", 32'(busy), 0);
    tick();
    chk("b0_no_start", 32'(tx_start), 0);
    rd(3'd3, 8'h04, "b0_err");
    wr(3'd3, 8'h04);
    rd(3'd3, 8'h00, "err_w1c");

    // BURST write while busy, then abort timing
    wr(3'd2, 8'd2);
    wr(3'd0, 8'h01);
    wr(3'd2, 8'd5);
    rd(3'd2, 8'd2, "burst_locked");
    rd(3'd3, 8'h05, "busy_err");
    wr(3'd0, 8'h02);
    chk("abort_lat_busy", 32'(busy), 1);
    chk("abort_lat_pulse", 32'(tx_abort), 0);
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pulse", 32'(tx_abort), 1);
    tick();
    chk("abort_pulse_width", 32'(tx_abort), 0);
    wr(3'd3, 8'h04);

    // Abort after first beat of a 4-beat burst
    wr(3'd2, 8'd4);
    wr(3'd0, 8'h01);
    tick();
    chk("ab4_start", 32'(tx_start), 1);
    tick(); tick();
    tx_beat_done = 1'b1;
    tick();
    tx_beat_done = 1'b0;
    wr(3'd0, 8'h02);
    chk("ab4_pend_busy", 32'(busy), 1);
    tick();
    chk("ab4_busy", 32'(busy), 0);
    chk("ab4_pulse", 32'(tx_abort), 1);
    chk("ab4_no_start", 32'(tx_start), 0);
    tick();
    chk("ab4_pulse_width", 32'(tx_abort), 0);
    rd(3'd4, 8'd3, "ab4_remain");
    rd(3'd3, 8'h00, "ab4_status");
    tx_beat_done = 1'b1;
    tick();
    tx_beat_done = 1'b0;
    rd(3'd4, 8'd3, "spurious_remain");
    rd(3'd3, 8'h00, "spurious_status");

    // ABORT in IDLE, and START+ABORT together
    wr(3'd0, 8'h02);
    tick();
    chk("idle_abort", 32'(tx_abort), 0);
    wr(3'd0, 8'h03);
    chk("start_abort_busy", 32'(busy), 0);
    rd(3'd3, 8'h00, "start_abort_status");

    // DONE set and W1C in the same cycle: set wins
    wr(3'd2, 8'd1);
    wr(3'd0, 8'h01);
    tick();
    tx_beat_done = 1'b1;
    wr(3'd3, 8'h02);
    tx_beat_done = 1'b0;
    chk("setclr_busy", 32'(busy), 0);
    rd(3'd3, 8'h02, "set_wins");
    wr(3'd3, 8'h02);

    // Reset mid-burst
    wr(3'd2, 8'd3);
    wr(3'd0, 8'h01);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_tx_start", 32'(tx_start), 0);
    chk("mrst_tx_size", 32'(tx_size), 0);
    chk("mrst_rvalid", 32'(rvalid), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_quiet", 32'({tx_start, tx_abort}), 0);
    end
    rd(3'd1, 8'h00, "mrst_size");
    rd(3'd2, 8'h00, "mrst_burst");
    rd(3'd4, 8'h00, "mrst_remain");
    rd(3'd3, 8'h00, "mrst_status");

`ifdef TXCTRL_IRQ_EN
    // Completion interrupt
    wr(3'd0, 8'h04);
    rd(3'd0, 8'h04, "irq_en_rb");
    wr(3'd2, 8'd1);
    wr(3'd0, 8'h05);
    tick();
    tx_beat_done = 1'b1;
    tick();
    tx_beat_done = 1'b0;
    chk("irq_lag", 32'(irq), 0);
    tick();
    chk("irq_rise", 32'(irq), 1);
    wr(3'd3, 8'h02);
    chk("irq_hold", 32'(irq), 1);
    tick();
    chk("irq_fall", 32'(irq), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
